// File: rtl/adbg_wb_pkg.sv
// Shared Wishbone cycle-type / burst-type encodings and the slave FSM state type.
package adbg_wb_pkg;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR  = 2'b00;
    localparam logic [1:0] WRAP4   = 2'b01;
    localparam logic [1:0] WRAP8   = 2'b10;
    localparam logic [1:0] WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/adbg_wb_burst_addr.sv
// Next word address of a Wishbone incrementing burst, linear or wrapping.
module adbg_wb_burst_addr
    import adbg_wb_pkg::*;
#(
    parameter int AW = 30
) (
    input  logic [AW-1:0] addr,
    input  logic [1:0]    bte,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] mask;
    logic [AW-1:0] incr;

    // Bits under the mask increment modulo the wrap size; bits above it are kept.
    always_comb begin
        mask = '1;
        case (bte)
            WRAP4:   mask = AW'(3);
            WRAP8:   mask = AW'(7);
            WRAP16:  mask = AW'(15);
            default: mask = '1;
        endcase
        incr      = addr + AW'(1);
        next_addr = (addr & ~mask) | (incr & mask);
    end

endmodule

// File: rtl/adbg_wb_slave_mem.sv
// Wishbone B3 slave backed by a byte-writable RAM, with wait states and
// classic / incrementing-burst support.
module adbg_wb_slave_mem
    import adbg_wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);

    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SEL_W = DATA_WIDTH / 8;

    state_t                state;
    logic [3:0]            cnt;
    logic [WA_W-1:0]       word_addr;
    logic [WA_W-1:0]       next_addr;
    logic                  below_base;
    logic                  req;
    logic                  addr_err;
    logic                  beat_done;
    logic                  mem_we;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign req       = wb_cyc_i & wb_stb_i;
    assign idx       = word_addr[IDX_W-1:0];
    assign addr_err  = below_base
                     | ({2'b00, word_addr} >= ADDR_WIDTH'(DEPTH))
                     | (wb_sel_i == '0);
    assign beat_done = (state == WAIT) && req && (cnt == '0);
    // State is forced to IDLE while reset is low, so no write can slip through.
    assign mem_we    = beat_done & wb_we_i & ~addr_err;

    adbg_wb_burst_addr #(
        .AW(WA_W)
    ) u_burst_addr (
        .addr      (word_addr),
        .bte       (wb_bte_i),
        .next_addr (next_addr)
    );

    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < SEL_W; b++) begin
                if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    // WAIT always holds at least one cycle so each beat's bus values are
    // sampled after the master has advanced past the previous ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
            word_addr  <= '0;
            below_base <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        word_addr  <= WA_W'((wb_adr_i - BASE_ADDR) >> 2);
                        below_base <= (wb_adr_i < BASE_ADDR);
                        cnt        <= 4'(WAIT_STATES);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= RESP;
                        if (addr_err) begin
                            wb_err_o <= 1'b1;
                        end else begin
                            wb_ack_o <= 1'b1;
                            if (!wb_we_i) wb_dat_o <= mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (req && (wb_cti_i == INCR)) begin
                        word_addr  <= next_addr;
                        below_base <= 1'b0;
                        cnt        <= 4'(WAIT_STATES);
                        state      <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adbg_wb_slave_mem.sv
// Directed bench for adbg_wb_slave_mem: one instance with no wait states, one with three.
module tb_adbg_wb_slave_mem;
    import adbg_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        which;
    logic [31:0] dat0, dat3, rdat;
    logic        ack0, ack3, err0, err3, ack, err;
    logic [31:0] bdat [4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign ack  = which ? ack3 : ack0;
    assign err  = which ? err3 : err0;
    assign rdat = which ? dat3 : dat0;

    adbg_wb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .wb_clk_i (clk),          .wb_rst_ni (rst_n),
        .wb_cyc_i (cyc & ~which), .wb_stb_i  (stb & ~which),
        .wb_we_i  (we),           .wb_cti_i  (cti),
        .wb_bte_i (bte),          .wb_adr_i  (adr),
        .wb_sel_i (sel),          .wb_dat_i  (wdat),
        .wb_dat_o (dat0),         .wb_ack_o  (ack0),
        .wb_err_o (err0)
    );

    adbg_wb_slave_mem #(.WAIT_STATES(3)) u_dut3 (
        .wb_clk_i (clk),          .wb_rst_ni (rst_n),
        .wb_cyc_i (cyc & which),  .wb_stb_i  (stb & which),
        .wb_we_i  (we),           .wb_cti_i  (cti),
        .wb_bte_i (bte),          .wb_adr_i  (adr),
        .wb_sel_i (sel),          .wb_dat_i  (wdat),
        .wb_dat_o (dat3),         .wb_ack_o  (ack3),
        .wb_err_o (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack | err) && n < 40);
    endtask

    // Single classic transfer; the master holds the bus through the ack cycle.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic exp_err, input int exp_lat, input logic [31:0] exp_dat);
        int n;
        logic got_ack, got_err;
        logic [31:0] got_dat;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        cti = CLASSIC; bte = LINEAR;
        wait_resp(n);
        got_ack = ack; got_err = err; got_dat = rdat;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({tag, "_ack"}, 32'(got_ack), 32'(!exp_err));
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_lat"}, 32'(n - 1), 32'(exp_lat));
        if (!w) check({tag, "_dat"}, got_dat, exp_dat);
        check({tag, "_idle"}, 32'(ack | err), 32'd0);
    endtask

    // Wrap-4 burst from 0x0C; later beats present a bogus address that must be ignored.
    task automatic burst(input string tag, input logic w);
        int   n;
        logic extra;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = WRAP4; adr = 32'h0C;
        for (int k = 0; k < 4; k++) begin
            cti  = (k == 3) ? EOB : INCR;
            wdat = bdat[k];
            wait_resp(n);
            check($sformatf("%s_b%0d_ack", tag, k), 32'(ack), 32'd1);
            if (!w) check($sformatf("%s_b%0d_dat", tag, k), rdat, bdat[k]);
            @(posedge clk); #1;
            adr = 32'h3F0;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CLASSIC; bte = LINEAR;
        extra = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            extra |= ack | err;
        end
        check({tag, "_end"}, 32'(extra), 32'd0);
    endtask

    initial begin
        logic seen;
        int   n;
        rst_n = 1'b0; which = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CLASSIC; bte = LINEAR;
        adr = '0; sel = '0; wdat = '0;
        bdat[0] = 32'hA0A0A0A0; bdat[1] = 32'hB1B1B1B1;
        bdat[2] = 32'hC2C2C2C2; bdat[3] = 32'hD3D3D3D3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_dat", dat0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("wr10",   1'b1, 32'h10,  4'hF,    32'hDEADBEEF, 1'b0, 1, 32'h0);
        xfer("rd10",   1'b0, 32'h10,  4'hF,    32'h0,        1'b0, 1, 32'hDEADBEEF);
        xfer("wr20a",  1'b1, 32'h20,  4'hF,    32'h11223344, 1'b0, 1, 32'h0);
        xfer("wr20b",  1'b1, 32'h20,  4'b0001, 32'h000000AA, 1'b0, 1, 32'h0);
        xfer("rd20a",  1'b0, 32'h20,  4'hF,    32'h0,        1'b0, 1, 32'h112233AA);
        xfer("wr20c",  1'b1, 32'h20,  4'b0100, 32'h00550000, 1'b0, 1, 32'h0);
        xfer("rd20b",  1'b0, 32'h20,  4'b0001, 32'h0,        1'b0, 1, 32'h115533AA);
        xfer("wr00",   1'b1, 32'h00,  4'hF,    32'h01020304, 1'b0, 1, 32'h0);
        xfer("wr400",  1'b1, 32'h400, 4'hF,    32'hFFFFFFFF, 1'b1, 1, 32'h0);
        xfer("rd00",   1'b0, 32'h00,  4'hF,    32'h0,        1'b0, 1, 32'h01020304);
        xfer("rd400",  1'b0, 32'h400, 4'hF,    32'h0,        1'b1, 1, 32'h01020304);
        xfer("wrsel0", 1'b1, 32'h10,  4'h0,    32'h0,        1'b1, 1, 32'h0);
        xfer("rd10b",  1'b0, 32'h10,  4'hF,    32'h0,        1'b0, 1, 32'hDEADBEEF);

        burst("bwr", 1'b1);
        xfer("rdw3",  1'b0, 32'h0C, 4'hF, 32'h0, 1'b0, 1, 32'hA0A0A0A0);
        xfer("rdw0",  1'b0, 32'h00, 4'hF, 32'h0, 1'b0, 1, 32'hB1B1B1B1);
        xfer("rdw1",  1'b0, 32'h04, 4'hF, 32'h0, 1'b0, 1, 32'hC2C2C2C2);
        xfer("rdw2",  1'b0, 32'h08, 4'hF, 32'h0, 1'b0, 1, 32'hD3D3D3D3);
        xfer("rdw4",  1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1, 32'hDEADBEEF);
        burst("brd", 1'b0);

        which = 1'b1;
        xfer("ws3wr", 1'b1, 32'h40, 4'hF, 32'h12345678, 1'b0, 4, 32'h0);
        xfer("ws3rd", 1'b0, 32'h40, 4'hF, 32'h0,        1'b0, 4, 32'h12345678);

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; wdat = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= ack | err;
        end
        check("abort_noresp", 32'(seen), 32'd0);
        xfer("abort_rd", 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 4, 32'h12345678);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40; sel = 4'hF;
        wait_resp(n);
        check("rstack_seen", 32'(ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstack_ack", 32'(ack), 32'd0);
        check("rstack_dat", rdat, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; wdat = 32'hBADBAD00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstwait_ack", 32'(ack), 32'd0);
        check("rstwait_err", 32'(err), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer("rstwait_rd", 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 4, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
